// File: rtl/audio_pkt_packer.sv
// rtl/audio_pkt_packer.sv - multi-channel audio frame FIFO and UDP payload packer
module audio_pkt_packer #(
   parameter int CH_NUM         = 2,
   parameter int FRAMES_PER_PKT = 128,
   parameter int FIFO_DEPTH     = 1024,
   parameter int SEQ_EN         = 1,
   parameter int TIMEOUT        = 65535
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable,
   input  logic                 frame_valid,
   input  logic [CH_NUM*32-1:0] frame_data,
   output logic                 tx_start_en,
   output logic [15:0]          tx_byte_num,
   input  logic                 tx_req,
   output logic [31:0]          tx_data,
   input  logic                 tx_done,
   output logic [15:0]          seq_num,
   output logic [15:0]          ovf_cnt,
   output logic                 timeout_flag
);

   localparam int AW        = $clog2(FIFO_DEPTH);
   localparam int CW        = AW + 1;
   localparam int PKT_DATA  = CH_NUM * FRAMES_PER_PKT;
   localparam int PKT_WORDS = PKT_DATA + SEQ_EN;

   localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] CH_C       = CW'(CH_NUM);
   localparam logic [CW-1:0] PKT_DATA_C = CW'(PKT_DATA);
   localparam logic [3:0]    CH_LEFT    = 4'(CH_NUM);
   localparam logic [15:0]   LAST_WORD  = 16'(PKT_WORDS - 1);
   localparam logic [15:0]   PKT_DATA_W = 16'(PKT_DATA);
   localparam logic [15:0]   BYTE_NUM   = 16'(4 * PKT_WORDS);
   localparam logic [31:0]   TMO_LAST   = 32'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, START, SEND, WAIT_DONE} state_t;

   state_t state, next_state;

   // word FIFO storage and pointers
   logic [31:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;

   // frame serializer: top 32 bits stay zero so the shift works for CH_NUM=1
   logic [CH_NUM*32+31:0] frame_reg;
   logic [3:0]            ser_left;

   logic [15:0] word_cnt;   // words issued in current packet, header included
   logic [15:0] pop_cnt;    // FIFO words popped in current packet
   logic [15:0] drain_cnt;  // words still to discard after an abort
   logic [31:0] tmo_cnt;

   logic ser_busy, accept, drop, wr_en;
   logic hdr_slot, issue, send_pop, drain_pop, pop;
   logic tmo_hit, done_now, abort_now;

   assign ser_busy  = (ser_left != 4'd0);
   assign accept    = frame_valid && enable && !ser_busy && ((DEPTH_C - count) >= CH_C);
   assign drop      = frame_valid && enable && !accept;
   assign wr_en     = ser_busy;
   assign hdr_slot  = (SEQ_EN != 0) && (word_cnt == 16'd0);
   assign issue     = (state == SEND) && tx_req;
   assign send_pop  = issue && !hdr_slot;
   assign drain_pop = (drain_cnt != 16'd0) && (count != '0);
   assign pop       = send_pop || drain_pop;
   assign tmo_hit   = (tmo_cnt == TMO_LAST);
   assign done_now  = (state == WAIT_DONE) && tx_done;
   assign abort_now = tmo_hit && ((state == SEND) || ((state == WAIT_DONE) && !tx_done));

   // next-state decode and start pulse
   always_comb begin
      next_state  = state;
      tx_start_en = 1'b0;
      case (state)
         IDLE: begin
            if ((drain_cnt == 16'd0) && (count >= PKT_DATA_C)) next_state = START;
         end
         START: begin
            tx_start_en = 1'b1;
            next_state  = SEND;
         end
         SEND: begin
            if (abort_now) next_state = IDLE;
            else if (issue && (word_cnt == LAST_WORD)) next_state = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (done_now || abort_now) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   // latch an accepted frame and shift it out one channel per cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_reg <= '0;
         ser_left  <= 4'd0;
      end else if (accept) begin
         frame_reg <= {32'h0, frame_data};
         ser_left  <= CH_LEFT;
      end else if (ser_busy) begin
         frame_reg <= {32'h0, frame_reg[CH_NUM*32+31:32]};
         ser_left  <= ser_left - 4'd1;
      end
   end

   // FIFO storage write
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= frame_reg[31:0];
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (pop)   rd_ptr <= rd_ptr + AW'(1);
         case ({wr_en, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // payload word register: header or registered FIFO read
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tx_data <= 32'h0;
      else if (issue) tx_data <= hdr_slot ? {16'hA5A5, seq_num} : mem[rd_ptr];
   end

   // per-packet counters, abort drain and timeout counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_cnt  <= 16'd0;
         pop_cnt   <= 16'd0;
         drain_cnt <= 16'd0;
         tmo_cnt   <= 32'd0;
      end else begin
         if (state == START) begin
            word_cnt <= 16'd0;
            pop_cnt  <= 16'd0;
            tmo_cnt  <= 32'd0;
         end else begin
            if (issue)    word_cnt <= word_cnt + 16'd1;
            if (send_pop) pop_cnt  <= pop_cnt + 16'd1;
            if ((state == SEND) || (state == WAIT_DONE)) tmo_cnt <= tmo_cnt + 32'd1;
         end
         if (abort_now)      drain_cnt <= PKT_DATA_W - pop_cnt - {15'd0, send_pop};
         else if (drain_pop) drain_cnt <= drain_cnt - 16'd1;
      end
   end

   // status outputs: sequence number, overflow count, timeout flag, byte count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seq_num      <= 16'd0;
         ovf_cnt      <= 16'd0;
         timeout_flag <= 1'b0;
         tx_byte_num  <= 16'd0;
      end else begin
         tx_byte_num <= BYTE_NUM;
         if (done_now || abort_now) seq_num <= seq_num + 16'd1;
         if (abort_now) timeout_flag <= 1'b1;
         if (drop && (ovf_cnt != 16'hFFFF)) ovf_cnt <= ovf_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_audio_pkt_packer.sv
// tb/tb_audio_pkt_packer.sv - directed self-checking bench for audio_pkt_packer
module tb_audio_pkt_packer;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        en_a, fv_a, start_a, req_a, done_a, flag_a;
   logic [63:0] fd_a;
   logic [15:0] bytes_a, seq_a, ovf_a;
   logic [31:0] data_a;

   logic        en_b, fv_b, start_b, req_b, done_b, flag_b;
   logic [31:0] fd_b, data_b;
   logic [15:0] bytes_b, seq_b, ovf_b;

   audio_pkt_packer #(.CH_NUM(2), .FRAMES_PER_PKT(4), .FIFO_DEPTH(16), .SEQ_EN(1), .TIMEOUT(100)) dut_a (
      .clk(clk), .rst_n(rst_n), .enable(en_a), .frame_valid(fv_a), .frame_data(fd_a),
      .tx_start_en(start_a), .tx_byte_num(bytes_a), .tx_req(req_a), .tx_data(data_a),
      .tx_done(done_a), .seq_num(seq_a), .ovf_cnt(ovf_a), .timeout_flag(flag_a));

   audio_pkt_packer #(.CH_NUM(1), .FRAMES_PER_PKT(4), .FIFO_DEPTH(16), .SEQ_EN(0), .TIMEOUT(100)) dut_b (
      .clk(clk), .rst_n(rst_n), .enable(en_b), .frame_valid(fv_b), .frame_data(fd_b),
      .tx_start_en(start_b), .tx_byte_num(bytes_b), .tx_req(req_b), .tx_data(data_b),
      .tx_done(done_b), .seq_num(seq_b), .ovf_cnt(ovf_b), .timeout_flag(flag_b));

   typedef struct packed {
      logic [3:0][31:0] ch0;
      logic [3:0][31:0] ch1;
      logic [8:0][31:0] exp;
      logic [15:0]      seq_after;
   } pkt_vec_t;

   pkt_vec_t vecs [3];
   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic feed_a(input logic [31:0] ch1, input logic [31:0] ch0);
      fv_a = 1'b1;
      fd_a = {ch1, ch0};
      tick();
      fv_a = 1'b0;
      tick();
      tick();
   endtask

   task automatic wait_start(input bit sel_b, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 80 && !ok; i++) begin
         if ((sel_b ? start_b : start_a) == 1'b1) ok = 1'b1;
         else tick();
      end
      check("start_seen", {31'd0, ok}, 32'd1);
   endtask

   function automatic logic [8:0][31:0] mk_exp(input logic [15:0] seq, input logic [31:0] base);
      logic [8:0][31:0] e;
      e[0] = {16'hA5A5, seq};
      for (int f = 0; f < 4; f++) begin
         e[1 + 2*f] = base + 32'(f);
         e[2 + 2*f] = 32'h1000_0000 + base + 32'(f);
      end
      return e;
   endfunction

   task automatic feed4_a(input logic [31:0] base);
      for (int f = 0; f < 4; f++) feed_a(32'h1000_0000 + base + 32'(f), base + 32'(f));
   endtask

   task automatic run_pkt_a(input logic [8:0][31:0] exp, input string tag);
      bit ok;
      wait_start(1'b0, ok);
      if (ok) begin
         tick();
         check({tag, "_start_1cyc"}, {31'd0, start_a}, 32'd0);
         req_a = 1'b1;
         for (int w = 0; w < 9; w++) begin
            tick();
            check($sformatf("%s_w%0d", tag, w), data_a, exp[w]);
         end
         tick();
         check({tag, "_hold"}, data_a, exp[8]);
         req_a = 1'b0;
         done_a = 1'b1;
         tick();
         done_a = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bit ok;
      int t_send;
      int starts;

      vecs[0].ch0 = {32'h0000_0003, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000};
      vecs[0].ch1 = {32'h1000_0003, 32'h1000_0002, 32'h1000_0001, 32'h1000_0000};
      vecs[0].exp = {32'h1000_0003, 32'h0000_0003, 32'h1000_0002, 32'h0000_0002,
                     32'h1000_0001, 32'h0000_0001, 32'h1000_0000, 32'h0000_0000, 32'hA5A5_0000};
      vecs[0].seq_after = 16'd1;
      vecs[1].ch0 = {32'hC0DE_0003, 32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000};
      vecs[1].ch1 = {32'hBEEF_0003, 32'hBEEF_0002, 32'hBEEF_0001, 32'hBEEF_0000};
      vecs[1].exp = {32'hBEEF_0003, 32'hC0DE_0003, 32'hBEEF_0002, 32'hC0DE_0002,
                     32'hBEEF_0001, 32'hC0DE_0001, 32'hBEEF_0000, 32'hC0DE_0000, 32'hA5A5_0001};
      vecs[1].seq_after = 16'd2;
      vecs[2].ch0 = {32'h0000_0000, 32'hFFFF_FFFF, 32'h89AB_CDEF, 32'h0123_4567};
      vecs[2].ch1 = {32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'h7FFF_FFFF, 32'h8000_0000};
      vecs[2].exp = {32'hA5A5_A5A5, 32'h0000_0000, 32'h5A5A_5A5A, 32'hFFFF_FFFF,
                     32'h7FFF_FFFF, 32'h89AB_CDEF, 32'h8000_0000, 32'h0123_4567, 32'hA5A5_0002};
      vecs[2].seq_after = 16'd3;

      rst_n = 1'b0;
      en_a = 1'b1; fv_a = 1'b0; fd_a = '0; req_a = 1'b0; done_a = 1'b0;
      en_b = 1'b1; fv_b = 1'b0; fd_b = '0; req_b = 1'b0; done_b = 1'b0;
      tick();
      tick();
      check("rst_start", {31'd0, start_a}, 32'd0);
      check("rst_data", data_a, 32'd0);
      check("rst_seq", {16'd0, seq_a}, 32'd0);
      check("rst_ovf", {16'd0, ovf_a}, 32'd0);
      check("rst_flag", {31'd0, flag_a}, 32'd0);
      check("rst_bytes", {16'd0, bytes_a}, 32'd0);
      rst_n = 1'b1;
      tick();
      tick();
      check("bytes_a", {16'd0, bytes_a}, 32'd36);

      // table of back-to-back packets
      for (int v = 0; v < 3; v++) begin
         for (int f = 0; f < 4; f++) feed_a(vecs[v].ch1[f], vecs[v].ch0[f]);
         run_pkt_a(vecs[v].exp, $sformatf("pkt%0d", v));
         check($sformatf("pkt%0d_seq", v), {16'd0, seq_a}, {16'd0, vecs[v].seq_after});
      end
      check("ovf_after_pkts", {16'd0, ovf_a}, 32'd0);
      starts = 0;
      for (int i = 0; i < 30; i++) begin
         if (start_a) starts++;
         tick();
      end
      check("no_spurious_start", 32'(starts), 32'd0);

      // timeout abort after three words, then a frame-aligned packet
      feed4_a(32'h20);
      wait_start(1'b0, ok);
      tick();
      t_send = cyc;
      req_a = 1'b1;
      tick(); check("tmo_w0", data_a, 32'hA5A5_0003);
      tick(); check("tmo_w1", data_a, 32'h0000_0020);
      tick(); check("tmo_w2", data_a, 32'h1000_0020);
      req_a = 1'b0;
      feed4_a(32'h40);
      for (int i = 0; i < 150 && !flag_a; i++) tick();
      check("tmo_flag", {31'd0, flag_a}, 32'd1);
      check("tmo_cycles", 32'(cyc - t_send), 32'd100);
      check("tmo_seq", {16'd0, seq_a}, 32'd4);
      run_pkt_a(mk_exp(16'd4, 32'h40), "post_tmo");
      check("post_tmo_seq", {16'd0, seq_a}, 32'd5);
      check("flag_sticky", {31'd0, flag_a}, 32'd1);

      // reset in the middle of SEND
      feed4_a(32'h60);
      wait_start(1'b0, ok);
      tick();
      req_a = 1'b1;
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      check("mid_rst_data", data_a, 32'd0);
      check("mid_rst_seq", {16'd0, seq_a}, 32'd0);
      check("mid_rst_flag", {31'd0, flag_a}, 32'd0);
      check("mid_rst_start", {31'd0, start_a}, 32'd0);
      req_a = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      check("bytes_after_rst", {16'd0, bytes_a}, 32'd36);
      feed4_a(32'h70);
      run_pkt_a(mk_exp(16'd0, 32'h70), "post_rst");
      check("post_rst_seq", {16'd0, seq_a}, 32'd1);

      // overflow: busy-serializer drop, then FIFO-full drops with no tx_req
      fv_a = 1'b1; fd_a = {32'h1000_0080, 32'h0000_0080};
      tick();
      fd_a = {32'h1000_0081, 32'h0000_0081};
      tick();
      fv_a = 1'b0;
      tick();
      tick();
      check("ovf_busy", {16'd0, ovf_a}, 32'd1);
      for (int f = 0; f < 9; f++) feed_a(32'h1000_0090 + 32'(f), 32'h90 + 32'(f));
      check("ovf_full", {16'd0, ovf_a}, 32'd3);
      en_a = 1'b0; fv_a = 1'b1;
      tick();
      fv_a = 1'b0; en_a = 1'b1;
      tick();
      check("ovf_disabled", {16'd0, ovf_a}, 32'd3);

      // single channel, no header
      check("bytes_b", {16'd0, bytes_b}, 32'd16);
      for (int f = 0; f < 4; f++) begin
         fv_b = 1'b1; fd_b = 32'h5500_0000 + 32'(f);
         tick();
         fv_b = 1'b0;
         tick();
         tick();
      end
      wait_start(1'b1, ok);
      if (ok) begin
         tick();
         req_b = 1'b1;
         for (int w = 0; w < 4; w++) begin
            tick();
            check($sformatf("b_w%0d", w), data_b, 32'h5500_0000 + 32'(w));
         end
         req_b = 1'b0;
         done_b = 1'b1;
         tick();
         done_b = 1'b0;
         check("b_seq", {16'd0, seq_b}, 32'd1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
